// File: rtl/mpu_if_pkg.sv
// Shared definitions for the MPU read interface: register map, register bit
// positions and the bus-access FSM states.
package mpu_if_pkg;

    // Register addresses (low two bits of mpu_addr)
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS register bits
    localparam int unsigned STATUS_READY_BIT     = 0;
    localparam int unsigned STATUS_IRQ_EN_BIT    = 1;
    localparam int unsigned STATUS_UNDERFLOW_BIT = 2;

    // CTRL register bits
    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRIVE,
        WREL
    } state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous control bit. The reset value is
// a parameter so active-low strobes come out of reset in their idle state.
module sync_bit #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= {STAGES{RESET_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/mpu_rd_if.sv
// Bridge between the tag data buffer and the asynchronous MPU memory bus.
// Each DATA read pops exactly one buffer word; STATUS, COUNT and CTRL form a
// small register file. Define MPU_RD_IF_IRQ_EN to build the data-ready
// interrupt and the CTRL irq_en bit; otherwise mpu_irq is tied low.
module mpu_rd_if
    import mpu_if_pkg::*;
#(
    parameter int unsigned          READ_WIDTH  = 16,
    parameter int unsigned          ADDR_WIDTH  = 2,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          READ_LAT    = 2,
    parameter logic [READ_WIDTH-1:0] EMPTY_WORD = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_ready,
    input  logic [READ_WIDTH-1:0] buf_data,
    output logic                  buf_rd_ena,
    input  logic                  mpu_cs_n,
    input  logic                  mpu_rd_n,
    input  logic                  mpu_wr_n,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [READ_WIDTH-1:0] mpu_data_i,
    output logic [READ_WIDTH-1:0] mpu_data_o,
    output logic                  mpu_data_oe,
    output logic                  mpu_irq
);

    localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);

    logic cs_s, rd_s, wr_s;
    logic strobe, strobe_q, start_q;

    state_t                state_q;
    logic                  is_rd_q;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [READ_WIDTH-1:0] wdata_q;
    logic [7:0]            lat_cnt_q;
    logic [15:0]           count_q;
    logic                  underflow_q;
    logic                  irq_en;
    logic [READ_WIDTH-1:0] rd_value;
    logic                  unused_bits;

    sync_bit #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync_cs (
        .clk(clk),
        .rst(rst),
        .d  (mpu_cs_n),
        .q  (cs_s)
    );

    sync_bit #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync_rd (
        .clk(clk),
        .rst(rst),
        .d  (mpu_rd_n),
        .q  (rd_s)
    );

    sync_bit #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync_wr (
        .clk(clk),
        .rst(rst),
        .d  (mpu_wr_n),
        .q  (wr_s)
    );

    assign strobe = ~cs_s & (~rd_s | ~wr_s);

    // Register the strobe fall so an access starts once per high-to-low edge
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            strobe_q <= strobe;
            start_q  <= strobe & ~strobe_q;
        end
    end

    // Read data selected by the captured address at the end of ACCESS
    always_comb begin
        rd_value = '0;
        unique case (addr_q[1:0])
            ADDR_DATA:   rd_value = hit_q ? buf_data : EMPTY_WORD;
            ADDR_STATUS: begin
                rd_value[STATUS_READY_BIT]     = buf_ready;
                rd_value[STATUS_IRQ_EN_BIT]    = irq_en;
                rd_value[STATUS_UNDERFLOW_BIT] = underflow_q;
            end
            ADDR_COUNT:  rd_value = READ_WIDTH'(count_q);
            ADDR_CTRL:   rd_value[CTRL_IRQ_EN_BIT] = irq_en;
        endcase
    end

`ifdef MPU_RD_IF_IRQ_EN
    logic irq_en_q;
    assign irq_en = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    // Bus-access FSM with its registered outputs and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_rd_q     <= 1'b0;
            hit_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            buf_rd_ena  <= 1'b0;
            mpu_data_o  <= '0;
            mpu_data_oe <= 1'b0;
`ifdef MPU_RD_IF_IRQ_EN
            irq_en_q    <= 1'b0;
`endif
        end else begin
            // Pads follow the state one cycle late: on after data is loaded,
            // off one cycle after the strobe release is seen
            mpu_data_oe <= (state_q == DRIVE);
            unique case (state_q)
                IDLE: begin
                    buf_rd_ena <= 1'b0;
                    // Both rd_n and wr_n low is not a legal access
                    if (start_q && strobe && (rd_s || wr_s)) begin
                        state_q   <= ACCESS;
                        is_rd_q   <= ~rd_s;
                        addr_q    <= mpu_addr;
                        wdata_q   <= mpu_data_i;
                        lat_cnt_q <= '0;
                        hit_q     <= 1'b0;
                        if (!rd_s && mpu_addr[1:0] == ADDR_DATA) begin
                            if (buf_ready) begin
                                buf_rd_ena <= 1'b1;
                                hit_q      <= 1'b1;
                                count_q    <= count_q + 16'd1;
                            end else begin
                                underflow_q <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (is_rd_q) begin
                        if (lat_cnt_q == LAT_LAST) begin
                            state_q    <= DRIVE;
                            mpu_data_o <= rd_value;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + 8'd1;
                        end
                    end else begin
                        state_q <= WREL;
                        if (addr_q[1:0] == ADDR_CTRL) begin
`ifdef MPU_RD_IF_IRQ_EN
                            irq_en_q <= wdata_q[CTRL_IRQ_EN_BIT];
`endif
                            if (wdata_q[CTRL_CLEAR_BIT]) begin
                                count_q     <= '0;
                                underflow_q <= 1'b0;
                            end
                        end
                    end
                end
                DRIVE: begin
                    if (rd_s || cs_s) begin
                        state_q    <= IDLE;
                        buf_rd_ena <= 1'b0;
                    end
                end
                WREL: begin
                    if (wr_s || cs_s) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MPU_RD_IF_IRQ_EN
    // Data-ready interrupt, one register stage behind its sources
    always_ff @(posedge clk) begin
        if (rst) begin
            mpu_irq <= 1'b0;
        end else begin
            mpu_irq <= irq_en & buf_ready;
        end
    end
`else
    assign mpu_irq = 1'b0;
`endif

    // Only some captured write-data and address bits reach the register file
    assign unused_bits = ^{wdata_q, addr_q};

endmodule

// File: doc/mpu_rd_if.md
# mpu_rd_if

Bus-slave bridge between the tag data buffer's microcontroller port and the external microprocessor's asynchronous parallel memory bus. Synchronizes the processor's chip-select/read/write strobes into `clk`, converts each data-address read into exactly one buffer pop, and returns the popped word on a tri-stated data bus. It also exposes a small register file: status, pop counter and control, plus an optional data-ready interrupt. Sits directly downstream of the tag data buffer in `mpu_if`; the MPU pins go to the FPGA top level.

## Interface
- `READ_WIDTH`, 16, buffer word and MPU data-bus width
- `ADDR_WIDTH`, 2, MPU address width (4 registers)
- `SYNC_STAGES`, 2, synchronizer depth on `mpu_cs_n`, `mpu_rd_n` and `mpu_wr_n` (≥2)
- `READ_LAT`, 2, cycles from `buf_rd_ena` rise to capture of `buf_data` (≥2)
- `EMPTY_WORD`, 16'h0000, value returned when the data register is read while the buffer is empty
- `clk`  in  1  core clock
- `rst`  in  1  reset; synchronous, active-high
- `buf_ready`  in  1  buffer non-empty
- `buf_data`  in  READ_WIDTH  buffer read data
- `buf_rd_ena`  out  1  read-enable level; the buffer pops on its rising edge
- `mpu_cs_n`, `mpu_rd_n`, `mpu_wr_n`  in  1 each  asynchronous MPU strobes, active-low
- `mpu_addr`  in  ADDR_WIDTH  register address; stable while a strobe is low
- `mpu_data_i`  in  READ_WIDTH  write data; stable while `mpu_wr_n` is low
- `mpu_data_o`  out  READ_WIDTH  read data, registered
- `mpu_data_oe`  out  1  tri-state enable for the data pads
- `mpu_irq`  out  1  data-ready interrupt, active-high

## Operation
- Register map:
  - 0 DATA: read pops one word. Writes are ignored.
  - 1 STATUS: read-only. `{13'b0, underflow, irq_en, buf_ready}`.
  - 2 COUNT: read-only. 16-bit count of successful pops; wraps at 0xFFFF→0.
  - 3 CTRL: bit0 `irq_en` (read/write). Writing bit1=1 clears COUNT and `underflow`; bit1 self-clears and reads 0.
- An access starts when the synchronized `cs_n`, ANDed with `rd_n` or `wr_n`, is sampled low after having been high. If `rd_n` and `wr_n` are both low, the access is ignored and the FSM stays in IDLE.
- FSM states:
  - IDLE → ACCESS on a valid strobe fall. `mpu_addr` is captured at this transition, and `mpu_data_i` too for writes.
  - ACCESS (read): lasts READ_LAT cycles. For DATA with `buf_ready`=1, `buf_rd_ena`=1 from the first ACCESS cycle and COUNT increments once. For DATA with `buf_ready`=0, there is no pop, `underflow` is set sticky, and the captured value is EMPTY_WORD.
  - ACCESS (write): lasts 1 cycle and updates CTRL.
  - ACCESS → DRIVE (read) or WREL (write).
  - DRIVE: `mpu_data_o` is loaded on entry and `mpu_data_oe`=1. Exit to IDLE when the synchronized `rd_n` or `cs_n` is high.
  - WREL: exit to IDLE when the synchronized `wr_n` or `cs_n` is high.
- `buf_rd_ena` stays high through DRIVE and drops on entry to IDLE. It is therefore low for ≥1 cycle between pops: exactly one pop per strobe.
- `buf_ready` is sampled once, on the first ACCESS cycle; later changes do not affect the access.

## Timing
- Reset values: `buf_rd_ena`=0, `mpu_data_o`=0, `mpu_data_oe`=0, `mpu_irq`=0, COUNT=0, `underflow`=0, `irq_en`=0, state IDLE. Reset mid-access aborts immediately: pads release on the next cycle and no pending pop completes.
- Read latency: `mpu_data_oe` rises and `mpu_data_o` is valid SYNC_STAGES+READ_LAT+2 cycles after the first edge that samples `mpu_rd_n` low. This is 6 cycles at defaults; the MPU read strobe must be programmed to ≥7 `clk` periods.
- Release: `mpu_data_oe` falls SYNC_STAGES+1 cycles after `mpu_rd_n` rises. The MPU must allow this in its bus turnaround time.
- Minimum strobe-high time between accesses: SYNC_STAGES+2 cycles.
- COUNT increment and `underflow` set both take effect on the cycle after ACCESS entry, and are visible to any following STATUS/COUNT read.

## Configuration
- `MPU_RD_IF_IRQ_EN` defined:
  - `mpu_irq` = `irq_en & buf_ready`, registered (1-cycle delay).
  - The irq level drops within 1 cycle of `buf_ready` falling or of `irq_en` being cleared.
- Undefined:
  - `mpu_irq` is tied 0.
  - CTRL bit0 is not implemented and reads 0.
  - STATUS bit1 reads 0.

## Structure
- Package `mpu_if_pkg` holds:
  - register address constants (`ADDR_DATA`, `ADDR_STATUS`, `ADDR_COUNT`, `ADDR_CTRL`);
  - the STATUS/CTRL bit indices;
  - the FSM state enum (IDLE, ACCESS, DRIVE, WREL).
- One sub-module, `sync_bit`: a SYNC_STAGES-deep flop synchronizer with a parameterized reset value of 1. It is instantiated three times, once per strobe.

## Test plan
- Buffer preloaded with 0x1234, 0x5678; two DATA reads of 8 cycles each → `mpu_data_o` returns 0x1234 then 0x5678; exactly 2 rising edges on `buf_rd_ena`; COUNT reads 2.
- DATA read with `buf_ready`=0 → returns 0x0000, no `buf_rd_ena` edge; STATUS reads 0x0004.
- Write 0x0002 to CTRL → COUNT reads 0 and STATUS bit2=0; CTRL reads back 0x0000.
- With `MPU_RD_IF_IRQ_EN`: write CTRL=0x0001, then `buf_ready` rises → `mpu_irq`=1 one cycle later; it drops within 1 cycle of draining the last word.
- `mpu_rd_n` and `mpu_wr_n` low together → no pop, no register change, `mpu_data_oe` stays 0.
- `rst` asserted in DRIVE → `mpu_data_oe`=0 and `buf_rd_ena`=0 next cycle; the next read completes normally.
